sequence_multiplier: RTL and testbench

SEQUENCE_MULTIPLIER -- requirements
Module: sequence_multiplier

---
 rtl/quantum_pkg.sv | 63 ++++++
 rtl/gate_rom.sv | 43 ++++
 rtl/sequence_multiplier.sv | 167 ++++++++++++++++
 tb/tb_sequence_multiplier.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quantum_pkg.sv
// rtl/quantum_pkg.sv - shared types, defaults and gate table for the sequence multiplier
// Contents: state_t (controller states), GATE_COUNT, numeric defaults,
// GATE_TABLE (25 single-qubit gates, Q1.17 components), gate_component().
package quantum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_MULT  = 2'd3
    } state_t;

    localparam int GATE_COUNT           = 25;
    localparam int NUMERIC_BITS_DEFAULT = 19;
    localparam int FRAC_BITS_DEFAULT    = 17;
    localparam int TABLE_FRAC_BITS      = 17;

    localparam int Q1 = 131072;   // 1.0
    localparam int RS = 92682;    // 1/sqrt(2)
    localparam int HF = 65536;    // 0.5

    // Per gate: {m00re, m00im, m01re, m01im, m10re, m10im, m11re, m11im}
    localparam int GATE_TABLE [GATE_COUNT][8] = '{
        '{ Q1,   0,   0,   0,   0,   0,  Q1,   0},   //  0 I
        '{  0,   0,  Q1,   0,  Q1,   0,   0,   0},   //  1 X
        '{  0,   0,   0, -Q1,   0,  Q1,   0,   0},   //  2 Y
        '{ Q1,   0,   0,   0,   0,   0, -Q1,   0},   //  3 Z
        '{ RS,   0,  RS,   0,  RS,   0, -RS,   0},   //  4 H
        '{ Q1,   0,   0,   0,   0,   0,   0,  Q1},   //  5 S
        '{ Q1,   0,   0,   0,   0,   0,   0, -Q1},   //  6 S-dagger
        '{ Q1,   0,   0,   0,   0,   0,  RS,  RS},   //  7 T
        '{ Q1,   0,   0,   0,   0,   0,  RS, -RS},   //  8 T-dagger
        '{ HF,  HF,  HF, -HF,  HF, -HF,  HF,  HF},   //  9 sqrt(X)
        '{ HF, -HF,  HF,  HF,  HF,  HF,  HF, -HF},   // 10 sqrt(X)-dagger
        '{ RS,   0,   0, -RS,   0, -RS,  RS,   0},   // 11 RX(+pi/2)
        '{ RS,   0,   0,  RS,   0,  RS,  RS,   0},   // 12 RX(-pi/2)
        '{ RS,   0, -RS,   0,  RS,   0,  RS,   0},   // 13 RY(+pi/2)
        '{ RS,   0,  RS,   0, -RS,   0,  RS,   0},   // 14 RY(-pi/2)
        '{ RS, -RS,   0,   0,   0,   0,  RS,  RS},   // 15 RZ(+pi/2)
        '{ RS,  RS,   0,   0,   0,   0,  RS, -RS},   // 16 RZ(-pi/2)
        '{-Q1,   0,   0,   0,   0,   0, -Q1,   0},   // 17 -I
        '{  0,  Q1,   0,   0,   0,   0,   0,  Q1},   // 18 iI
        '{  0, -Q1,   0,   0,   0,   0,   0, -Q1},   // 19 -iI
        '{  0,   0, -Q1,   0, -Q1,   0,   0,   0},   // 20 -X
        '{-Q1,   0,   0,   0,   0,   0,  Q1,   0},   // 21 -Z
        '{  0,   0,   0,  Q1,   0,  Q1,   0,   0},   // 22 iX
        '{  0,  Q1,   0,   0,   0,   0,   0, -Q1},   // 23 iZ
        '{ RS,   0,   0,  RS,  RS,   0,   0, -RS}    // 24 H*S
    };

    // Table entry rescaled from Q.17 to the requested fractional width.
    function automatic longint gate_component(input logic [4:0] code,
                                              input logic [2:0] k,
                                              input int frac_bits);
        longint v;
        v = longint'(GATE_TABLE[code][k]);
        if (frac_bits >= TABLE_FRAC_BITS)
            return v <<< (frac_bits - TABLE_FRAC_BITS);
        else
            return v >>> (TABLE_FRAC_BITS - frac_bits);
    endfunction

endpackage

// File: rtl/gate_rom.sv
// rtl/gate_rom.sv - registered 1-cycle gate matrix lookup
// Ports: clk, reset (sync, active-high), i_en (load new lookup), i_gate (code),
// o_matrix (8 packed components, m00re in MSBs), o_invalid (code >= 25, identity returned).
module gate_rom
    import quantum_pkg::*;
#(
    parameter int NUMERIC_BITS = NUMERIC_BITS_DEFAULT,
    parameter int FRAC_BITS    = FRAC_BITS_DEFAULT
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_en,
    input  logic [4:0]                i_gate,
    output logic [8*NUMERIC_BITS-1:0] o_matrix,
    output logic                      o_invalid
);

    logic                      w_invalid;
    logic [4:0]                w_code;
    logic [8*NUMERIC_BITS-1:0] w_matrix;

    // Unknown codes fall back to entry 0, which is the identity.
    assign w_invalid = int'(i_gate) >= GATE_COUNT;
    assign w_code    = w_invalid ? 5'd0 : i_gate;

    always_comb begin
        w_matrix = '0;
        for (int k = 0; k < 8; k++)
            w_matrix[(7-k)*NUMERIC_BITS +: NUMERIC_BITS] =
                NUMERIC_BITS'(gate_component(w_code, 3'(k), FRAC_BITS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_matrix  <= '0;
            o_invalid <= 1'b0;
        end else if (i_en) begin
            o_matrix  <= w_matrix;
            o_invalid <= w_invalid;
        end
    end

endmodule

// File: rtl/sequence_multiplier.sv
// rtl/sequence_multiplier.sv - accumulates the 2x2 complex product of a gate sequence
// Ports: clk, reset (sync, active-high); seq_index/seq_gate/ready/first offer a gate,
// available accepts it; result (8 packed components), result_valid pulse, overflow sticky.
// Build option: SEQ_MULT_SATURATE_EN selects clamping instead of wrapping on overflow.
module sequence_multiplier
    import quantum_pkg::*;
#(
    parameter int SEQ_INDEX_BITS = 5,
    parameter int NUMERIC_BITS   = NUMERIC_BITS_DEFAULT,
    parameter int FRAC_BITS      = FRAC_BITS_DEFAULT
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEQ_INDEX_BITS-1:0] seq_index,
    input  logic [4:0]                seq_gate,
    input  logic                      ready,
    input  logic                      first,
    output logic                      available,
    output logic [8*NUMERIC_BITS-1:0] result,
    output logic                      result_valid,
    output logic                      overflow
);

    localparam int N  = NUMERIC_BITS;
    localparam int PW = 2*NUMERIC_BITS + 2;   // room for four summed partial products

    state_t                r_state;
    logic [1:0]            r_ent;             // entry under MULT: m00, m01, m10, m11
    logic                  r_first;
    logic                  r_last;
    logic                  r_result_valid;
    logic                  r_overflow;
    logic signed [N-1:0]   r_cache [0:7];
    logic signed [N-1:0]   r_stage [0:5];     // first three entries of the new cache

    logic                  w_accept;
    logic [8*N-1:0]        w_rom_matrix;
    logic                  w_rom_invalid;
    logic signed [N-1:0]   w_g [0:7];
    logic signed [N-1:0]   w_a0r, w_a0i, w_a1r, w_a1i;
    logic signed [N-1:0]   w_g0r, w_g0i, w_g1r, w_g1i;
    logic signed [PW-1:0]  w_sum_re, w_sum_im;
    logic [N:0]            w_red_re, w_red_im;

    function automatic logic signed [PW-1:0] scaled_product(input logic signed [N-1:0] a,
                                                            input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return PW'(p >>> FRAC_BITS);
    endfunction

    // Returns {out_of_range, reduced value}.
    function automatic logic [N:0] range_reduce(input logic signed [PW-1:0] s);
        logic       ovf;
        logic [N-1:0] v;
        ovf = !((&s[PW-1:N-1]) || !(|s[PW-1:N-1]));
`ifdef SEQ_MULT_SATURATE_EN
        if (ovf)
            v = s[PW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            v = s[N-1:0];
`else
        v = s[N-1:0];
`endif
        return {ovf, v};
    endfunction

    // A first gate completes in LOAD with the cache already written, so the
    // next gate may be taken there as well as in IDLE.
    assign available = !reset && (r_state == ST_IDLE || r_state == ST_LOAD);
    assign w_accept  = ready && available;

    gate_rom #(
        .NUMERIC_BITS (NUMERIC_BITS),
        .FRAC_BITS    (FRAC_BITS)
    ) u_gate_rom (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_accept),
        .i_gate    (seq_gate),
        .o_matrix  (w_rom_matrix),
        .o_invalid (w_rom_invalid)
    );

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_g[k] = w_rom_matrix[(7-k)*N +: N];
            result[(7-k)*N +: N] = r_cache[k];
        end
    end

    // Entry (row, col) = A[row][0]*G[0][col] + A[row][1]*G[1][col].
    assign w_a0r = r_cache[{r_ent[1], 2'b00}];
    assign w_a0i = r_cache[{r_ent[1], 2'b01}];
    assign w_a1r = r_cache[{r_ent[1], 2'b10}];
    assign w_a1i = r_cache[{r_ent[1], 2'b11}];
    assign w_g0r = w_g[{1'b0, r_ent[0], 1'b0}];
    assign w_g0i = w_g[{1'b0, r_ent[0], 1'b1}];
    assign w_g1r = w_g[{1'b1, r_ent[0], 1'b0}];
    assign w_g1i = w_g[{1'b1, r_ent[0], 1'b1}];

    assign w_sum_re = scaled_product(w_a0r, w_g0r) - scaled_product(w_a0i, w_g0i)
                    + scaled_product(w_a1r, w_g1r) - scaled_product(w_a1i, w_g1i);
    assign w_sum_im = scaled_product(w_a0r, w_g0i) + scaled_product(w_a0i, w_g0r)
                    + scaled_product(w_a1r, w_g1i) + scaled_product(w_a1i, w_g1r);

    assign w_red_re = range_reduce(w_sum_re);
    assign w_red_im = range_reduce(w_sum_im);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_ent          <= 2'd0;
            r_first        <= 1'b0;
            r_last         <= 1'b0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
            for (int k = 0; k < 8; k++) r_cache[k] <= '0;
            for (int k = 0; k < 6; k++) r_stage[k] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept) begin
                        r_state <= ST_FETCH;
                        r_first <= first;
                        r_last  <= (seq_index == '0);
                        if (first) r_overflow <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    r_ent <= 2'd0;
                    if (w_rom_invalid) r_overflow <= 1'b1;
                    if (r_first) begin
                        r_cache        <= w_g;
                        r_result_valid <= r_last;
                        r_state        <= ST_LOAD;
                    end else begin
                        r_state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (w_red_re[N] || w_red_im[N]) r_overflow <= 1'b1;
                    r_ent <= r_ent + 2'd1;
                    if (r_ent == 2'd3) begin
                        // Whole cache replaced in one edge so MULT never sees a mix.
                        for (int k = 0; k < 6; k++) r_cache[k] <= r_stage[k];
                        r_cache[6]     <= w_red_re[N-1:0];
                        r_cache[7]     <= w_red_im[N-1:0];
                        r_result_valid <= r_last;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_stage[{r_ent, 1'b0}] <= w_red_re[N-1:0];
                        r_stage[{r_ent, 1'b1}] <= w_red_im[N-1:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_sequence_multiplier.sv
// tb/tb_sequence_multiplier.sv - randomized self-checking bench against a matrix reference model
module tb_sequence_multiplier;

    localparam int     N    = 19;
    localparam longint ONE  = 131072;
    localparam longint RS2  = 92682;
    localparam longint MAXV = 262143;
    localparam longint MINV = -262144;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [4:0]     seq_index = 5'd0;
    logic [4:0]     seq_gate = 5'd0;
    logic           ready = 1'b0;
    logic           first = 1'b0;
    logic           available;
    logic [8*N-1:0] result;
    logic           result_valid;
    logic           overflow;

    int     n_vec = 0;
    int     n_err = 0;
    longint model_m [8];
    longint gate_m  [8];
    longint next_m  [8];
    bit     model_ovf;

    always #5 clk = ~clk;

    sequence_multiplier #(
        .SEQ_INDEX_BITS (5),
        .NUMERIC_BITS   (N),
        .FRAC_BITS      (17)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seq_index    (seq_index),
        .seq_gate     (seq_gate),
        .ready        (ready),
        .first        (first),
        .available    (available),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint comp(input int k);
        logic signed [N-1:0] v;
        v = result[(7-k)*N +: N];
        return longint'(v);
    endfunction

    function automatic longint abs_l(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Gate matrices as the reference knows them: I, X, Y, Z, H; anything above 24 is identity.
    task automatic load_gate(input int code);
        case (code)
            0:       gate_m = '{ONE, 0, 0, 0, 0, 0, ONE, 0};
            1:       gate_m = '{0, 0, ONE, 0, ONE, 0, 0, 0};
            2:       gate_m = '{0, 0, 0, -ONE, 0, ONE, 0, 0};
            3:       gate_m = '{ONE, 0, 0, 0, 0, 0, -ONE, 0};
            4:       gate_m = '{RS2, 0, RS2, 0, RS2, 0, -RS2, 0};
            default: gate_m = '{ONE, 0, 0, 0, 0, 0, ONE, 0};
        endcase
    endtask

    function automatic longint fx(input longint a, input longint b);
        return (a * b) >>> 17;   // floor of the Q.17 product
    endfunction

    function automatic longint reduce(input longint s);
        longint w;
`ifdef SEQ_MULT_SATURATE_EN
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
`else
        w = s & 64'h7FFFF;
        if (w > MAXV) w = w - 524288;
        return w;
`endif
    endfunction

    task automatic model_apply(input bit f, input int code);
        longint re, im;
        load_gate(code);
        if (f) begin
            model_m   = gate_m;
            model_ovf = 1'b0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    re = 0;
                    im = 0;
                    for (int k = 0; k < 2; k++) begin
                        re += fx(model_m[4*r+2*k], gate_m[4*k+2*c]) - fx(model_m[4*r+2*k+1], gate_m[4*k+2*c+1]);
                        im += fx(model_m[4*r+2*k], gate_m[4*k+2*c+1]) + fx(model_m[4*r+2*k+1], gate_m[4*k+2*c]);
                    end
                    if (re > MAXV || re < MINV || im > MAXV || im < MINV) model_ovf = 1'b1;
                    next_m[4*r+2*c]   = reduce(re);
                    next_m[4*r+2*c+1] = reduce(im);
                end
            end
            model_m = next_m;
        end
        if (code > 24) model_ovf = 1'b1;
    endtask

    task automatic check_result(input string tag);
        for (int k = 0; k < 8; k++)
            check_eq($sformatf("%s.c%0d", tag, k), comp(k), model_m[k]);
    endtask

    // Called at a falling edge with the block expected to be available.
    task automatic send_gate(input int code, input bit f, input int idx);
        int cyc;
        int pulses;
        seq_gate  = 5'(code);
        first     = f;
        seq_index = 5'(idx);
        ready     = 1'b1;
        check_eq("avail_at_offer", longint'(available), 1);
        @(posedge clk);
        @(negedge clk);
        ready  = 1'b0;
        first  = 1'b0;
        cyc    = 1;
        pulses = 0;
        model_apply(f, code);
        while (!available && cyc < 20) begin
            if (result_valid) pulses++;
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", cyc, f ? 2 : 6);
        check_eq("early_pulse", pulses, 0);
        check_eq("result_valid", longint'(result_valid), (idx == 0) ? 1 : 0);
        check_eq("overflow", longint'(overflow), longint'(model_ovf));
        if (idx == 0) check_result("result");
    endtask

    initial begin
        int len;
        int code;
        int pulses;
        bit f;

        for (int k = 0; k < 8; k++) model_m[k] = 0;
        model_ovf = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_available", longint'(available), 0);
        check_eq("rst_result_valid", longint'(result_valid), 0);
        check_eq("rst_overflow", longint'(overflow), 0);
        check_eq("rst_result", longint'(result == '0), 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("avail_after_rst", longint'(available), 1);

        // Identity as a single first gate
        send_gate(0, 1'b1, 0);
        check_eq("id_m00re", comp(0), ONE);
        check_eq("id_m11re", comp(6), ONE);
        check_eq("id_m01re", comp(2), 0);

        // X then X
        send_gate(1, 1'b1, 1);
        send_gate(1, 1'b0, 0);
        check_eq("xx_m00re", comp(0), ONE);
        check_eq("xx_m11re", comp(6), ONE);
        check_eq("xx_ovf", longint'(overflow), 0);

        // X then Z
        send_gate(1, 1'b1, 1);
        send_gate(3, 1'b0, 0);
        check_eq("xz_m01re", comp(2), -ONE);
        check_eq("xz_m10re", comp(4), ONE);
        check_eq("xz_m00re", comp(0), 0);

        // H then H: rounding keeps it near identity
        send_gate(4, 1'b1, 1);
        send_gate(4, 1'b0, 0);
        check_eq("hh_m00re_tol", longint'(abs_l(comp(0) - ONE) <= 2), 1);
        check_eq("hh_m11re_tol", longint'(abs_l(comp(6) - ONE) <= 2), 1);
        check_eq("hh_m01re_tol", longint'(abs_l(comp(2)) <= 2), 1);
        check_eq("hh_m10re_tol", longint'(abs_l(comp(4)) <= 2), 1);

        // Invalid code, then a clean first gate clears overflow
        send_gate(31, 1'b1, 0);
        check_eq("inv_ovf", longint'(overflow), 1);
        check_eq("inv_m00re", comp(0), ONE);
        send_gate(0, 1'b1, 0);
        check_eq("clr_ovf", longint'(overflow), 0);

        // Random sequences, occasional mid-sequence restart and idle gaps
        for (int s = 0; s < 30; s++) begin
            len = $urandom_range(1, 5);
            for (int i = len - 1; i >= 0; i--) begin
                code = ($urandom_range(0, 9) == 0) ? $urandom_range(25, 31) : $urandom_range(0, 4);
                f    = (i == len - 1) || ($urandom_range(0, 15) == 0);
                send_gate(code, f, i);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // Reset while a multiply is in flight
        send_gate(1, 1'b1, 1);
        seq_gate  = 5'd3;
        first     = 1'b0;
        seq_index = 5'd0;
        ready     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready  = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (result_valid) pulses++;
        check_eq("midrst_available", longint'(available), 0);
        check_eq("midrst_result", longint'(result == '0), 1);
        check_eq("midrst_overflow", longint'(overflow), 0);
        reset = 1'b0;
        @(negedge clk);
        if (result_valid) pulses++;
        check_eq("midrst_avail_after", longint'(available), 1);
        check_eq("midrst_no_pulse", pulses, 0);
        for (int k = 0; k < 8; k++) model_m[k] = 0;
        model_ovf = 1'b0;

        send_gate(2, 1'b1, 1);
        send_gate(2, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
